// File: rtl/mean_filter_pkg.sv
// Shared definitions for the mean-filter pipeline: frame sequencer states and
// default timing geometry used by the RTL and the filter testbenches.
package mean_filter_pkg;

    localparam int DEF_DW    = 8;
    localparam int DEF_H_ACT = 4;
    localparam int DEF_V_ACT = 2;
    localparam int DEF_V_BP  = 8;
    localparam int DEF_H_GAP = 5;
    localparam int DEF_V_FP  = 3;
    localparam int DEF_V_GAP = 30;
    localparam int DEF_CW    = 12;

    typedef enum logic [2:0] {
        S_IDLE,
        S_VBP,
        S_ACTIVE,
        S_HGAP,
        S_VFP,
        S_VGAP
    } frame_state_t;

    // States during which the field sync is asserted.
    function automatic logic in_field(input frame_state_t s);
        return (s == S_VBP) || (s == S_ACTIVE) || (s == S_HGAP) || (s == S_VFP);
    endfunction

endpackage

// File: rtl/seg_counter.sv
// Loadable down-counter that times one frame segment; tc flags the final
// cycle of a segment that was loaded with its length in cycles.
module seg_counter
    import mean_filter_pkg::*;
#(
    parameter int CW = DEF_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] value,
    output logic          tc
);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign tc = (r_count == CW'(1));

endmodule

// File: rtl/mean_filter_frame_ctrl.sv
// Frame sequencer for the mean filter: generates vsync/hsync/pixel timing,
// pops pixels from the upstream source and flags source underflow.
module mean_filter_frame_ctrl
    import mean_filter_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int H_ACT = DEF_H_ACT,
    parameter int V_ACT = DEF_V_ACT,
    parameter int V_BP  = DEF_V_BP,
    parameter int H_GAP = DEF_H_GAP,
    parameter int V_FP  = DEF_V_FP,
    parameter int V_GAP = DEF_V_GAP,
    parameter int CW    = DEF_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    input  logic          src_valid,
    input  logic [DW-1:0] src_data,
    output logic          src_ready,
    output logic          dout_vsync,
    output logic          dout_hsync,
    output logic [DW-1:0] dout,
    output logic          underflow
);

    localparam logic [CW-1:0] L_H_ACT = CW'(H_ACT);
    localparam logic [CW-1:0] L_V_ACT = CW'(V_ACT);
    localparam logic [CW-1:0] L_V_BP  = CW'(V_BP);
    localparam logic [CW-1:0] L_H_GAP = CW'(H_GAP);
    localparam logic [CW-1:0] L_V_FP  = CW'(V_FP);
    localparam logic [CW-1:0] L_V_GAP = CW'(V_GAP);

    frame_state_t  r_state;
    frame_state_t  w_state_next;
    logic          w_load;
    logic [CW-1:0] w_load_val;
    logic          w_tc;
    logic [CW-1:0] r_lines_left;
    logic          w_last_line;
    logic          w_start_acc;

    logic          r_vsync;
    logic          r_hsync;
    logic          r_busy;
    logic          r_done;
    logic [DW-1:0] r_dout;
    logic          r_underflow;

    seg_counter #(
        .CW(CW)
    ) u_seg (
        .clk  (clk),
        .rst  (rst),
        .load (w_load),
        .value(w_load_val),
        .tc   (w_tc)
    );

    assign w_last_line = (r_lines_left <= CW'(1));
    assign w_start_acc = (r_state == S_IDLE) && start;

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_load_val   = '0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_VBP;
                    w_load       = 1'b1;
                    w_load_val   = L_V_BP;
                end
            end
            S_VBP: begin
                if (w_tc) begin
                    w_state_next = S_ACTIVE;
                    w_load       = 1'b1;
                    w_load_val   = L_H_ACT;
                end
            end
            S_ACTIVE: begin
                if (w_tc) begin
                    w_load = 1'b1;
                    if (w_last_line) begin
                        w_state_next = S_VFP;
                        w_load_val   = L_V_FP;
                    end else begin
                        w_state_next = S_HGAP;
                        w_load_val   = L_H_GAP;
                    end
                end
            end
            S_HGAP: begin
                if (w_tc) begin
                    w_state_next = S_ACTIVE;
                    w_load       = 1'b1;
                    w_load_val   = L_H_ACT;
                end
            end
            S_VFP: begin
                if (w_tc) begin
                    w_state_next = S_VGAP;
                    w_load       = 1'b1;
                    w_load_val   = L_V_GAP;
                end
            end
            S_VGAP: begin
                if (w_tc) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Pop one cycle ahead so the registered pixel lines up with hsync.
    assign src_ready = !rst && (w_state_next == S_ACTIVE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_lines_left <= '0;
            r_vsync      <= 1'b0;
            r_hsync      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_dout       <= '0;
            r_underflow  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_vsync <= in_field(w_state_next);
            r_hsync <= (w_state_next == S_ACTIVE);
            r_busy  <= (w_state_next != S_IDLE);
            r_done  <= (r_state == S_VFP) && (w_state_next == S_VGAP);
            r_dout  <= (src_ready && src_valid) ? src_data : '0;

            if (w_start_acc) begin
                r_lines_left <= L_V_ACT;
            end else if ((r_state == S_ACTIVE) && w_tc && !w_last_line) begin
                r_lines_left <= r_lines_left - 1'b1;
            end

            if (w_start_acc) begin
                r_underflow <= 1'b0;
            end else if (src_ready && !src_valid) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign dout_vsync = r_vsync;
    assign dout_hsync = r_hsync;
    assign busy       = r_busy;
    assign done       = r_done;
    assign dout       = r_dout;
    assign underflow  = r_underflow;

endmodule

// File: tb/tb_mean_filter_frame_ctrl.sv
// Self-checking bench for mean_filter_frame_ctrl: default and minimal geometry
// instances compared cycle by cycle against a timing-formula reference model.
module tb_mean_filter_frame_ctrl;
    import mean_filter_pkg::*;

    typedef struct {
        int ha;
        int va;
        int vbp;
        int hg;
        int vfp;
        int vg;
    } geom_t;

    logic       clk;
    logic       rst;

    logic       start, src_valid, busy, done, src_ready;
    logic       dout_vsync, dout_hsync, underflow;
    logic [7:0] src_data, dout;

    logic       start_g, src_valid_g, busy_g, done_g, src_ready_g;
    logic       dout_vsync_g, dout_hsync_g, underflow_g;
    logic [7:0] src_data_g, dout_g;

    int         n_checks;
    int         n_fail;
    geom_t      g_def;
    geom_t      g_small;
    logic [7:0] slot_data  [0:15];
    logic       slot_valid [0:15];

    mean_filter_frame_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_ready (src_ready),
        .dout_vsync(dout_vsync),
        .dout_hsync(dout_hsync),
        .dout      (dout),
        .underflow (underflow)
    );

    mean_filter_frame_ctrl #(
        .H_ACT(1), .V_ACT(1), .V_BP(1), .H_GAP(1), .V_FP(1), .V_GAP(1)
    ) dut_g (
        .clk       (clk),
        .rst       (rst),
        .start     (start_g),
        .busy      (busy_g),
        .done      (done_g),
        .src_valid (src_valid_g),
        .src_data  (src_data_g),
        .src_ready (src_ready_g),
        .dout_vsync(dout_vsync_g),
        .dout_hsync(dout_hsync_g),
        .dout      (dout_g),
        .underflow (underflow_g)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: t counts cycles after the start-sampling edge (t=1 is
    // the first cycle with vsync high).
    function automatic int pix_index(input geom_t g, input int t);
        for (int k = 0; k < g.va; k++) begin
            int s;
            s = 1 + g.vbp + k * (g.ha + g.hg);
            if (t >= s && t < s + g.ha) return k * g.ha + (t - s);
        end
        return -1;
    endfunction

    function automatic int vs_len(input geom_t g);
        return g.vbp + g.va * g.ha + (g.va - 1) * g.hg + g.vfp;
    endfunction

    function automatic logic [13:0] exp_vec(input geom_t g, input int t);
        logic       e_vs, e_hs, e_busy, e_done, e_rdy, e_uf;
        logic [7:0] e_dout;
        int         p;
        p      = pix_index(g, t);
        e_vs   = (t >= 1) && (t <= vs_len(g));
        e_busy = (t >= 1) && (t <= vs_len(g) + g.vg);
        e_done = (t == vs_len(g) + 1);
        e_hs   = (p >= 0);
        e_rdy  = (pix_index(g, t + 1) >= 0);
        e_dout = (p >= 0 && slot_valid[p]) ? slot_data[p] : 8'h00;
        e_uf   = 1'b0;
        for (int j = 1; j <= t; j++) begin
            int q;
            q = pix_index(g, j);
            if (q >= 0 && !slot_valid[q]) e_uf = 1'b1;
        end
        return {e_vs, e_hs, e_busy, e_done, e_rdy, e_uf, e_dout};
    endfunction

    function automatic logic [13:0] obs_vec(input int which);
        if (which == 0)
            return {dout_vsync, dout_hsync, busy, done, src_ready, underflow, dout};
        return {dout_vsync_g, dout_hsync_g, busy_g, done_g, src_ready_g, underflow_g, dout_g};
    endfunction

    // Drive inputs for cycle t; pop cycles present the slot, others get noise.
    task automatic drive(input int which, input geom_t g, input int t, input logic st);
        int         p;
        logic       v;
        logic [7:0] d;
        p = pix_index(g, t + 1);
        if (p >= 0) begin
            v = slot_valid[p];
            d = slot_data[p];
        end else begin
            v = 1'($urandom_range(0, 1));
            d = 8'($urandom_range(0, 255));
        end
        if (which == 0) begin
            start = st; src_valid = v; src_data = d;
        end else begin
            start_g = st; src_valid_g = v; src_data_g = d;
        end
    endtask

    task automatic fill_slots(input int invalid_slot);
        for (int i = 0; i < 16; i++) begin
            slot_data[i]  = 8'($urandom_range(0, 255));
            slot_valid[i] = (i != invalid_slot);
        end
    endtask

    task automatic test_reset;
        logic [13:0] obs;
        rst = 1'b1;
        drive(0, g_def, -10, 1'b0);
        drive(1, g_small, -10, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            for (int w = 0; w < 2; w++) begin
                obs = obs_vec(w);
                n_checks++;
                if (obs !== 14'h0) begin
                    n_fail++;
                    $display("FAIL reset dut%0d cycle=%0d got=%h exp=%h", w, c, obs, 14'h0);
                end
            end
            if (c == 2) rst = 1'b0;
            drive(0, g_def, -10, 1'b0);
            drive(1, g_small, -10, 1'b0);
        end
    endtask

    task automatic test_single_frame;
        logic [13:0] obs, exp;
        int          vs_cnt, done_cnt;
        vs_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 16; i++) slot_valid[i] = 1'b1;
        {slot_data[0], slot_data[1], slot_data[2], slot_data[3]} = {8'd20, 8'd18, 8'd32, 8'd11};
        {slot_data[4], slot_data[5], slot_data[6], slot_data[7]} = {8'd51, 8'd33, 8'd67, 8'd2};
        drive(0, g_def, 0, 1'b1);
        for (int t = 1; t <= vs_len(g_def) + g_def.vg + 1; t++) begin
            @(negedge clk);
            obs = obs_vec(0);
            exp = exp_vec(g_def, t);
            vs_cnt += int'(dout_vsync);
            done_cnt += int'(done);
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL single_frame t=%0d got=%h exp=%h", t, obs, exp);
            end
            drive(0, g_def, t, 1'b0);
        end
        n_checks++;
        if (vs_cnt != 24) begin
            n_fail++;
            $display("FAIL single_frame_vsync_len got=%0d exp=%0d", vs_cnt, 24);
        end
        n_checks++;
        if (done_cnt != 1) begin
            n_fail++;
            $display("FAIL single_frame_done_count got=%0d exp=%0d", done_cnt, 1);
        end
    endtask

    task automatic test_underflow;
        logic [13:0] obs, exp;
        fill_slots(2);
        drive(0, g_def, 0, 1'b1);
        for (int t = 1; t <= vs_len(g_def) + g_def.vg + 3; t++) begin
            @(negedge clk);
            obs = obs_vec(0);
            exp = exp_vec(g_def, t);
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL underflow t=%0d got=%h exp=%h", t, obs, exp);
            end
            drive(0, g_def, t, 1'b0);
        end
    endtask

    task automatic test_start_while_busy;
        logic [13:0] obs, exp;
        int          last;
        last = vs_len(g_def) + g_def.vg;
        fill_slots(1);
        drive(0, g_def, 0, 1'b1);
        for (int t = 1; t <= last + 1; t++) begin
            @(negedge clk);
            obs = obs_vec(0);
            exp = exp_vec(g_def, t);
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL start_while_busy t=%0d got=%h exp=%h", t, obs, exp);
            end
            drive(0, g_def, t, (t == 5) || (t == 20) || (t == last));
        end
        // Start in the first IDLE cycle: the next frame follows back to back.
        fill_slots(-1);
        drive(0, g_def, 0, 1'b1);
        for (int t = 1; t <= last + 1; t++) begin
            @(negedge clk);
            obs = obs_vec(0);
            exp = exp_vec(g_def, t);
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL back_to_back t=%0d got=%h exp=%h", t, obs, exp);
            end
            drive(0, g_def, t, 1'b0);
        end
    endtask

    task automatic test_reset_mid_active;
        logic [13:0] obs, exp;
        int          rst_t;
        rst_t = 1 + g_def.vbp + (g_def.ha + g_def.hg) + 1;
        fill_slots(-1);
        drive(0, g_def, 0, 1'b1);
        for (int t = 1; t <= rst_t; t++) begin
            @(negedge clk);
            obs = obs_vec(0);
            exp = exp_vec(g_def, t);
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL reset_mid_pre t=%0d got=%h exp=%h", t, obs, exp);
            end
            drive(0, g_def, t, 1'b0);
        end
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            obs = obs_vec(0);
            n_checks++;
            if (obs !== 14'h0) begin
                n_fail++;
                $display("FAIL reset_mid_post cycle=%0d got=%h exp=%h", c, obs, 14'h0);
            end
            rst = 1'b0;
            drive(0, g_def, -10, 1'b0);
        end
        fill_slots(-1);
        drive(0, g_def, 0, 1'b1);
        for (int t = 1; t <= vs_len(g_def) + g_def.vg + 1; t++) begin
            @(negedge clk);
            obs = obs_vec(0);
            exp = exp_vec(g_def, t);
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL reset_mid_refresh t=%0d got=%h exp=%h", t, obs, exp);
            end
            drive(0, g_def, t, 1'b0);
        end
    endtask

    task automatic test_geometry_sweep;
        logic [13:0] obs, exp;
        for (int f = 0; f < 3; f++) begin
            fill_slots(f == 1 ? 0 : -1);
            drive(1, g_small, 0, 1'b1);
            for (int t = 1; t <= vs_len(g_small) + g_small.vg + 2; t++) begin
                @(negedge clk);
                obs = obs_vec(1);
                exp = exp_vec(g_small, t);
                n_checks++;
                if (obs !== exp) begin
                    n_fail++;
                    $display("FAIL geometry f=%0d t=%0d got=%h exp=%h", f, t, obs, exp);
                end
                drive(1, g_small, t, 1'b0);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        g_def    = '{ha: DEF_H_ACT, va: DEF_V_ACT, vbp: DEF_V_BP,
                     hg: DEF_H_GAP, vfp: DEF_V_FP, vg: DEF_V_GAP};
        g_small  = '{ha: 1, va: 1, vbp: 1, hg: 1, vfp: 1, vg: 1};
        fill_slots(-1);
        test_reset();
        test_single_frame();
        test_underflow();
        test_start_while_busy();
        test_reset_mid_active();
        test_geometry_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
